rx_ctrl_unit: RTL
=================

// Module: rx_ctrl_unit
// PURPOSE
// Receive control unit for the serial-in (UART-style) receiver; sits beside the bit timer.
// Synchronises serial_in, detects the start-bit falling edge and drives enable_timer.
// Consumes packet_done from the timer, checks the stop bit and issues load_buffer.
// Owns the framing_error, overrun_error and data_ready status flags.
// PARAMETERS
// SYNC_STAGES  2  flops in the serial_in synchroniser chain (legal 2..4)
// PORTS
// clk            in   1  system clock, all flops rising-edge
// rst            in   1  asynchronous, active-high reset
// serial_in      in   1  raw asynchronous line, idle high
// packet_done    in   1  timer rollover flag: all bits incl. stop bit sampled
// stop_bit       in   1  stop bit as captured by the shift register
// data_read      in   1  consumer has taken the buffered byte (1-cycle pulse)
// enable_timer   out  1  run the bit timer (timer clears itself when low)
// sbc_clear      out  1  1-cycle pulse: clear shift register/status at start of packet
// load_buffer    out  1  1-cycle pulse: copy shifted data into the RX buffer
// data_ready     out  1  RX buffer holds an unread byte
// framing_error  out  1  last packet had stop_bit==0
// overrun_error  out  1  a new byte was loaded while data_ready was still 1
// BEHAVIOUR
// - Reset: sync chain and edge flop = 1; state = IDLE; all outputs 0.
// - Sync: serial_in -> SYNC_STAGES flops -> sync_q; prev_q = sync_q delayed 1 cycle.
//   start_det = prev_q & ~sync_q, purely from flops (no comb path from serial_in).
//   A low on serial_in first sampled at edge k gives start_det high in the cycle after edge k+SYNC_STAGES.
// - FSM states, one transition per clk:
//   IDLE    : start_det ? CLEAR : IDLE.
//   CLEAR   : sbc_clear=1 for exactly this cycle; clears framing_error; -> RECEIVE.
//   RECEIVE : enable_timer=1; stay until packet_done==1, then -> STOP_CHK.
//             enable_timer drops on the same edge that enters STOP_CHK.
//   STOP_CHK: stop_bit==0 -> framing_error<=1, -> IDLE (no load).
//             stop_bit==1 -> LOAD.
//   LOAD    : load_buffer=1 for exactly this cycle; data_ready<=1;
//             overrun_error<=1 if data_ready already 1; -> IDLE.
// - Outputs enable_timer, sbc_clear and load_buffer are Moore (decoded from state only).
// - data_ready: set in LOAD; cleared on data_read. Same cycle LOAD & data_read -> stays 1
//   (new byte wins) and overrun is NOT flagged.
// - overrun_error: sticky; cleared only by data_read while in IDLE, or by rst.
// - framing_error: sticky until the next CLEAR, or rst.
// - Start edges seen in any state other than IDLE are ignored; no re-arm mid-packet.
// - packet_done outside RECEIVE is ignored.
// - A line glitch shorter than one clk may be missed; no glitch filter in this block.
// - rst mid-packet: immediate return to IDLE, all outputs 0, sync chain forced to 1.
//   A line still low after rst release does not register as a start.
//   A fresh 1->0 edge is needed before the next packet starts.
// - Undefined state encodings recover to IDLE (default branch).
// TESTING
// 1. Reset: rst=1 with serial_in=0 -> all outputs 0.
//    Release rst with serial_in held 0 for 20 cycles -> FSM stays IDLE, no sbc_clear.
// 2. Good frame: serial_in 1->0 at cycle 10 (SYNC_STAGES=2) -> sbc_clear pulse at cycle 13.
//    Then enable_timer high until packet_done, then STOP_CHK with stop_bit=1,
//    then load_buffer 1 cycle and data_ready=1.
// 3. Framing error: as 2 but stop_bit=0 in STOP_CHK -> framing_error=1, no load_buffer.
//    Next good frame clears framing_error at its sbc_clear.
// 4. Overrun: two good frames with no data_read between them -> 2nd load_buffer sets overrun_error.
//    data_read pulse in IDLE clears both data_ready and overrun_error.
// 5. Collision: data_read asserted in the LOAD cycle -> data_ready stays 1, overrun_error stays 0.
// 6. Mid-packet reset: assert rst while in RECEIVE -> enable_timer=0 immediately (async).
//    A falling edge in RECEIVE before the reset causes no restart.

Source files
------------

// File: rtl/rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// rx_ctrl_if
// Signal bundle between the UART receive control unit and its surroundings
// (line, bit timer, shift register, RX buffer consumer).
//   serial_in     : raw asynchronous line, idle high
//   packet_done   : bit timer rollover, all bits incl. stop bit sampled
//   stop_bit      : stop bit as captured by the shift register
//   data_read     : consumer took the buffered byte (1-cycle pulse)
//   enable_timer  : run the bit timer
//   sbc_clear     : 1-cycle pulse, clear shift register/status at packet start
//   load_buffer   : 1-cycle pulse, copy shifted data into the RX buffer
//   data_ready    : RX buffer holds an unread byte
//   framing_error : last packet had a low stop bit
//   overrun_error : a byte was loaded over an unread one
// master drives the line/timer/consumer side; slave is the control unit.
// -----------------------------------------------------------------------------
interface rx_ctrl_if;
  logic serial_in;
  logic packet_done;
  logic stop_bit;
  logic data_read;
  logic enable_timer;
  logic sbc_clear;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  modport master (
    output serial_in, packet_done, stop_bit, data_read,
    input  enable_timer, sbc_clear, load_buffer,
           data_ready, framing_error, overrun_error
  );

  modport slave (
    input  serial_in, packet_done, stop_bit, data_read,
    output enable_timer, sbc_clear, load_buffer,
           data_ready, framing_error, overrun_error
  );
endinterface

// File: rtl/rx_ctrl_unit.sv
// -----------------------------------------------------------------------------
// rx_ctrl_unit
// Receive control for a UART-style receiver. Synchronises serial_in, detects
// the start-bit falling edge, runs the bit timer for one packet, checks the
// stop bit and loads the RX buffer. Owns the data_ready, framing_error and
// overrun_error status flags. All outputs are registered.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : rx_ctrl_if.slave (see interface header for signal meanings)
// Parameter:
//   SYNC_STAGES : flops in the serial_in synchroniser chain, legal 2..4
// -----------------------------------------------------------------------------
module rx_ctrl_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  rx_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RECEIVE  = 3'd2,
    ST_STOP_CHK = 3'd3,
    ST_LOAD     = 3'd4
  } state_e;

  // Synchroniser: chain -> sync_q -> prev_q. A low sampled into the chain at
  // edge k reaches sync_q at edge k+SYNC_STAGES, so start_det is high in the
  // cycle after that edge.
  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q, sync_d;
  logic                   prev_q, prev_d;
  // fill_q[i] marks that pipeline position i holds a real line sample rather
  // than the forced reset value; a line held low through reset must not look
  // like a 1->0 edge once the forced 1s drain out.
  logic [SYNC_STAGES+1:0] fill_q, fill_d;
  logic                   start_det;

  state_e state_q, state_d;
  logic   enable_timer_q, enable_timer_d;
  logic   sbc_clear_q, sbc_clear_d;
  logic   load_buffer_q, load_buffer_d;
  logic   data_ready_q, data_ready_d;
  logic   framing_error_q, framing_error_d;
  logic   overrun_error_q, overrun_error_d;

  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], bus.serial_in};
    sync_d       = sync_chain_q[SYNC_STAGES-1];
    prev_d       = sync_q;
    fill_d       = {fill_q[SYNC_STAGES:0], 1'b1};
  end

  // Only flops feed start_det; no combinational path from serial_in.
  assign start_det = prev_q & ~sync_q & fill_q[SYNC_STAGES+1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d         = state_q;
    data_ready_d    = data_ready_q;
    framing_error_d = framing_error_q;
    overrun_error_d = overrun_error_q;

    if (bus.data_read) data_ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_read) overrun_error_d = 1'b0;
        if (start_det)     state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        framing_error_d = 1'b0;
        state_d         = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        if (bus.packet_done) state_d = ST_STOP_CHK;
      end
      ST_STOP_CHK: begin
        if (bus.stop_bit) begin
          state_d = ST_LOAD;
        end else begin
          framing_error_d = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A read landing in the load cycle consumed the old byte: the new byte
        // wins and nothing was lost.
        data_ready_d = 1'b1;
        if (data_ready_q && !bus.data_read) overrun_error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Moore outputs decoded from the next state, so the registered copies are
    // aligned with state_q.
    enable_timer_d = (state_d == ST_RECEIVE);
    sbc_clear_d    = (state_d == ST_CLEAR);
    load_buffer_d  = (state_d == ST_LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain_q    <= '1;
      sync_q          <= 1'b1;
      prev_q          <= 1'b1;
      fill_q          <= '0;
      state_q         <= ST_IDLE;
      enable_timer_q  <= 1'b0;
      sbc_clear_q     <= 1'b0;
      load_buffer_q   <= 1'b0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      sync_chain_q    <= sync_chain_d;
      sync_q          <= sync_d;
      prev_q          <= prev_d;
      fill_q          <= fill_d;
      state_q         <= state_d;
      enable_timer_q  <= enable_timer_d;
      sbc_clear_q     <= sbc_clear_d;
      load_buffer_q   <= load_buffer_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign bus.enable_timer  = enable_timer_q;
  assign bus.sbc_clear     = sbc_clear_q;
  assign bus.load_buffer   = load_buffer_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun_error = overrun_error_q;

endmodule
